// File: rtl/lifo_pop_stream.sv
// LIFO pop stage: issues pops to a synchronous LIFO, captures its registered
// read data one cycle later and re-presents the words as a valid/ready stream
// through a 2-entry buffer.
module lifo_pop_stream #(
  parameter int unsigned data_width = 8
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en,
  input  logic                  lifo_push,
  input  logic                  lifo_full,
  input  logic                  lifo_empty,
  input  logic [data_width-1:0] lifo_data_out,
  output logic                  lifo_pop,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [data_width-1:0] m_data,
  output logic                  busy
);

  logic [1:0]            cnt_q, cnt_d;
  logic                  inf_q, inf_d;
  logic                  head_q, head_d;
  logic                  tail_q, tail_d;
  logic [data_width-1:0] mem_q [2];

  logic [1:0] occ;
  logic       arrive;
  logic       depart;
  logic       hon;

  // Occupancy bookkeeping, pop issue and honoured-pop detection.
  always_comb begin
    // cnt max 2 plus inf max 1 fits in two bits
    occ      = cnt_q + {1'b0, inf_q};
    m_valid  = (cnt_q != 2'd0);
    m_data   = mem_q[head_q];
    depart   = m_valid & m_ready;
    arrive   = inf_q;
    busy     = m_valid | inf_q;
    // Only ask when the word is guaranteed a slot on arrival; the full-buffer
    // case relies on a departure at the same edge, hence m_ready -> lifo_pop.
    lifo_pop = clr_n & en & !lifo_empty &
               ((occ < 2'd2) | ((occ == 2'd2) & depart));
    // The LIFO services a push in preference to a pop in the same cycle.
    hon      = lifo_pop & !lifo_empty & !(lifo_push & !lifo_full);
  end

  // Next-state for counters and pointers.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    inf_d  = hon;
    if (arrive) tail_d = ~tail_q;
    if (depart) head_d = ~head_q;
    unique case ({arrive, depart})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; captured data lands in the tail slot.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q  <= 2'd0;
      inf_q  <= 1'b0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_d;
      inf_q  <= inf_d;
      head_q <= head_d;
      tail_q <= tail_d;
      if (arrive) mem_q[tail_q] <= lifo_data_out;
    end
  end

  // An arrival into a full buffer without a departure would drop a word.
  ap_no_overflow: assert property (@(posedge clk) disable iff (!clr_n)
    !(arrive && (cnt_q == 2'd2) && !depart));

endmodule

// File: tb/tb_lifo_pop_stream.sv
// Bench for lifo_pop_stream: a small behavioural LIFO feeds the DUT, a
// scoreboard queue holds hand-computed expected words and a monitor checks
// every accepted output word.
module tb_lifo_pop_stream;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       en;
  logic       lifo_push;
  logic       lifo_full;
  logic       lifo_empty;
  logic [7:0] lifo_data_out;
  logic       lifo_pop;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       busy;

  logic [7:0] din;
  logic [7:0] lmem [8];
  int         sp = 0;
  int         hon_cnt = 0;
  logic [7:0] sb [$];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  lifo_pop_stream #(.data_width(8)) dut (
    .clk           (clk),
    .clr_n         (clr_n),
    .en            (en),
    .lifo_push     (lifo_push),
    .lifo_full     (lifo_full),
    .lifo_empty    (lifo_empty),
    .lifo_data_out (lifo_data_out),
    .lifo_pop      (lifo_pop),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .busy          (busy)
  );

  // Behavioural LIFO, depth 8, push wins over pop, registered read data.
  assign lifo_empty = (sp == 0);
  assign lifo_full  = (sp == 8);
  initial lifo_data_out = 8'h00;
  always @(posedge clk) begin
    if (lifo_push && !lifo_full) begin
      lmem[sp] <= din;
      sp <= sp + 1;
    end else if (lifo_pop && !lifo_empty) begin
      lifo_data_out <= lmem[sp-1];
      sp <= sp - 1;
      hon_cnt <= hon_cnt + 1;
    end
  end

  // Monitor: each accepted word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (clr_n && m_valid && m_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %02h, expected no word", m_data);
      end else begin
        if (m_data !== sb[0]) begin
          errors++;
          $display("FAIL stream_data: got %02h, expected %02h", m_data, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    lifo_push = 1'b1;
    din = d;
    step();
    lifo_push = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      step();
      if (sb.size() == 0 && !busy) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (m_valid) seen = 1'b1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    int base;
    clr_n = 1'b0; en = 1'b0; lifo_push = 1'b0; m_ready = 1'b0; din = 8'h00;

    // Reset / idle
    step(); step();
    clr_n = 1'b1;
    en = 1'b1;
    @(negedge clk);
    chk("rst_valid", {31'd0, m_valid}, 0);
    chk("rst_pop", {31'd0, lifo_pop}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", {24'd0, m_data}, 0);
    step();
    en = 1'b0;

    // Streaming in reverse push order, three back-to-back words
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    sb.push_back(8'h33); sb.push_back(8'h22); sb.push_back(8'h11);
    en = 1'b1; m_ready = 1'b1;
    wait_valid("stream_first_valid");
    @(negedge clk); chk("stream_valid2", {31'd0, m_valid}, 1);
    @(negedge clk); chk("stream_valid3", {31'd0, m_valid}, 1);
    @(negedge clk); chk("stream_idle", {31'd0, m_valid}, 0);
    wait_drain("stream_drain");
    en = 1'b0; m_ready = 1'b0;

    // Back-pressure: only two pops while the consumer stalls
    push_word(8'hA0); push_word(8'hA1); push_word(8'hA2); push_word(8'hA3);
    base = hon_cnt;
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i >= 3) chk("bp_hold", {24'd0, m_data}, 32'hA3);
    end
    chk("bp_pops", hon_cnt - base, 2);
    chk("bp_valid", {31'd0, m_valid}, 1);
    chk("bp_no_pop", {31'd0, lifo_pop}, 0);
    chk("bp_lifo_left", sp, 2);
    sb.push_back(8'hA3); sb.push_back(8'hA2); sb.push_back(8'hA1); sb.push_back(8'hA0);
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("bp_burst_valid", {31'd0, m_valid}, 1);
    end
    @(negedge clk); chk("bp_burst_end", {31'd0, m_valid}, 0);
    wait_drain("bp_drain");
    en = 1'b0;

    // Push priority over pop in the same cycle
    push_word(8'h55);
    en = 1'b1; lifo_push = 1'b1; din = 8'h66;
    sb.push_back(8'h66); sb.push_back(8'h55);
    @(negedge clk); chk("prio_pop_req", {31'd0, lifo_pop}, 1);
    step();
    lifo_push = 1'b0;
    chk("prio_no_inflight", {31'd0, busy}, 0);
    chk("prio_lifo_depth", sp, 2);
    wait_drain("prio_drain");
    en = 1'b0;

    // Async reset between pop edge and capture edge
    m_ready = 1'b0;
    push_word(8'h77); push_word(8'h88);
    en = 1'b1;
    step();
    chk("arst_inflight", {31'd0, busy}, 1);
    #2;
    clr_n = 1'b0; en = 1'b0;
    #1;
    chk("arst_valid", {31'd0, m_valid}, 0);
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_pop", {31'd0, lifo_pop}, 0);
    step(); step();
    clr_n = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("arst_no_stale", {31'd0, m_valid}, 0);
    end
    sb.push_back(8'h77);
    en = 1'b1;
    wait_drain("arst_drain");
    chk("arst_lifo_empty", {31'd0, lifo_empty}, 1);
    en = 1'b0;

    // en dropped right after a pop issues
    push_word(8'h91); push_word(8'h92); push_word(8'h93);
    sb.push_back(8'h93);
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("en_no_pop", {31'd0, lifo_pop}, 0);
    end
    wait_drain("en_inflight_drain");
    chk("en_lifo_left", sp, 2);
    sb.push_back(8'h92); sb.push_back(8'h91);
    en = 1'b1;
    wait_drain("en_resume_drain");
    chk("end_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
